// File: rtl/xhdmiout_encoder.sv
// xhdmiout_encoder: HDMI TMDS channel encoder, one 10-bit symbol per pixel clock.
// Two register ranks: stage 1 holds the transition-minimised q_m plus mode and
// side-band bits; stage 2 applies DC balance and registers the output word.
// o_word[0] is the first bit on the wire.
// Optional feature: define XHDMIOUT_TERC4_EN to enable TERC4 data-island coding.
module xhdmiout_encoder (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_de,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctl,
  input  logic       i_island,
  input  logic [3:0] i_aux,
  output logic [9:0] o_word
);

  localparam logic [1:0] MODE_CTL  = 2'd0;
  localparam logic [1:0] MODE_VID  = 2'd1;
  localparam logic [1:0] MODE_TERC = 2'd2;

  localparam logic [9:0] TOK_CTL0 = 10'h354;

  logic [3:0]        w_n1;
  logic              w_use_xnor;
  logic [8:0]        w_qm;
  logic [1:0]        w_mode;

  logic [8:0]        r_qm;
  logic [1:0]        r_mode;
  logic [1:0]        r_ctl;
  logic [3:0]        r_aux;

  logic [3:0]        w_n1q;
  logic signed [5:0] w_step;
  logic              w_case_a;
  logic              w_case_b;
  logic signed [5:0] w_cnt_nxt;
  logic [9:0]        w_vid_word;
  logic [9:0]        w_ctl_word;
  logic [9:0]        w_terc_word;
  logic [9:0]        w_word_nxt;

  logic signed [5:0] r_cnt;
  logic [9:0]        r_word;

  // Mode select: video beats data island beats control
  always_comb begin
    w_mode = MODE_CTL;
    if (i_de) begin
      w_mode = MODE_VID;
    end else begin
`ifdef XHDMIOUT_TERC4_EN
      if (i_island) w_mode = MODE_TERC;
`endif
    end
  end

`ifndef XHDMIOUT_TERC4_EN
  logic w_unused_island;
  assign w_unused_island = ^{i_island, i_aux, r_aux};
`endif

  // Stage 1 combinational: popcount and XOR/XNOR chain
  always_comb begin
    w_n1 = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_n1 = w_n1 + {3'b000, i_data[i]};
    end
    w_use_xnor = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !i_data[0]);
    w_qm       = '0;
    w_qm[0]    = i_data[0];
    for (int unsigned i = 1; i < 8; i++) begin
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ i_data[i]) : (w_qm[i-1] ^ i_data[i]);
    end
    w_qm[8] = ~w_use_xnor;
  end

  // Stage 1 registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_qm   <= '0;
      r_mode <= MODE_CTL;
      r_ctl  <= '0;
      r_aux  <= '0;
    end else begin
      r_qm   <= w_qm;
      r_mode <= w_mode;
      r_ctl  <= i_ctl;
      r_aux  <= i_aux;
    end
  end

  // Stage 2 combinational: DC balance decision and running disparity update
  always_comb begin
    w_n1q = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_n1q = w_n1q + {3'b000, r_qm[i]};
    end
    // N1 - N0 == 2*N1 - 8
    w_step   = $signed({1'b0, w_n1q, 1'b0}) - 6'sd8;
    w_case_a = (r_cnt == 6'sd0) || (w_n1q == 4'd4);
    w_case_b = ((r_cnt > 6'sd0) && (w_n1q > 4'd4)) ||
               ((r_cnt < 6'sd0) && (w_n1q < 4'd4));
    if (w_case_a) begin
      w_vid_word = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
      w_cnt_nxt  = r_qm[8] ? (r_cnt + w_step) : (r_cnt - w_step);
    end else if (w_case_b) begin
      w_vid_word = {1'b1, r_qm[8], ~r_qm[7:0]};
      w_cnt_nxt  = r_cnt + (r_qm[8] ? 6'sd2 : 6'sd0) - w_step;
    end else begin
      w_vid_word = {1'b0, r_qm[8], r_qm[7:0]};
      w_cnt_nxt  = r_cnt - (r_qm[8] ? 6'sd0 : 6'sd2) + w_step;
    end
  end

  // Control token lookup
  always_comb begin
    case (r_ctl)
      2'b00:   w_ctl_word = 10'h354;
      2'b01:   w_ctl_word = 10'h0AB;
      2'b10:   w_ctl_word = 10'h154;
      default: w_ctl_word = 10'h2AB;
    endcase
  end

  // TERC4 lookup (constant control token when the feature is compiled out)
  always_comb begin
    w_terc_word = TOK_CTL0;
`ifdef XHDMIOUT_TERC4_EN
    case (r_aux)
      4'h0: w_terc_word = 10'h29C;
      4'h1: w_terc_word = 10'h263;
      4'h2: w_terc_word = 10'h2E4;
      4'h3: w_terc_word = 10'h2E2;
      4'h4: w_terc_word = 10'h171;
      4'h5: w_terc_word = 10'h11E;
      4'h6: w_terc_word = 10'h18E;
      4'h7: w_terc_word = 10'h13C;
      4'h8: w_terc_word = 10'h2CC;
      4'h9: w_terc_word = 10'h139;
      4'hA: w_terc_word = 10'h19C;
      4'hB: w_terc_word = 10'h2C6;
      4'hC: w_terc_word = 10'h28E;
      4'hD: w_terc_word = 10'h271;
      4'hE: w_terc_word = 10'h163;
      default: w_terc_word = 10'h2C3;
    endcase
`endif
  end

  // Output word select by registered mode
  always_comb begin
    case (r_mode)
      MODE_VID:  w_word_nxt = w_vid_word;
      MODE_TERC: w_word_nxt = w_terc_word;
      default:   w_word_nxt = w_ctl_word;
    endcase
  end

  // Stage 2 registers: output word and disparity (cleared by any non-video word)
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_word <= TOK_CTL0;
      r_cnt  <= '0;
    end else begin
      r_word <= w_word_nxt;
      r_cnt  <= (r_mode == MODE_VID) ? w_cnt_nxt : 6'sd0;
    end
  end

  assign o_word = r_word;

endmodule

// File: tb/tb_xhdmiout_encoder.sv
// Scoreboard bench for xhdmiout_encoder: the driver pushes expected words,
// a negedge monitor pops and compares two clocks later.
module tb_xhdmiout_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       de = 1'b0;
  logic [7:0] data = '0;
  logic [1:0] ctl = '0;
  logic       island = 1'b0;
  logic [3:0] aux = '0;
  logic [9:0] word;

  xhdmiout_encoder dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_de      (de),
    .i_data    (data),
    .i_ctl     (ctl),
    .i_island  (island),
    .i_aux     (aux),
    .o_word    (word)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       exact;  // compare whole word
    logic       vid;    // video word: decode + disparity tracking
    logic [9:0] w;
    logic [7:0] d;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic drove = 1'b0;
  logic [1:0] vp = '0;
  logic prev_rst_n = 1'b0;
  int   bal = 0;

  logic [9:0] CTL_TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  logic [9:0] TERC_TOK [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2,
                                10'h171, 10'h11E, 10'h18E, 10'h13C,
                                10'h2CC, 10'h139, 10'h19C, 10'h2C6,
                                10'h28E, 10'h271, 10'h163, 10'h2C3};

  always @(posedge clk) vp <= {vp[0], drove};

  function automatic logic [7:0] tmds_dec(input logic [9:0] w);
    logic [7:0] qq;
    logic [7:0] d;
    qq = w[9] ? ~w[7:0] : w[7:0];
    d[0] = qq[0];
    for (int i = 1; i < 8; i++)
      d[i] = w[8] ? (qq[i] ^ qq[i-1]) : ~(qq[i] ^ qq[i-1]);
    return d;
  endfunction

  function automatic int ones10(input logic [9:0] w);
    int n = 0;
    for (int i = 0; i < 10; i++) n += int'(w[i]);
    return n;
  endfunction

  // Monitor: one output word per clock once the pipeline is primed
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (vp[1]) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL underflow: word=%h with no expected entry", word);
        end else begin
          e = q.pop_front();
          checks++;
          if (e.exact) begin
            if (word !== e.w) begin
              errors++;
              $display("FAIL %s: got %h expected %h", e.name, word, e.w);
            end
          end else if (tmds_dec(word) !== e.d) begin
            errors++;
            $display("FAIL %s: word %h decodes to %h expected %h", e.name, word, tmds_dec(word), e.d);
          end
          if (e.vid) begin
            bal += 2 * ones10(word) - 10;
            checks++;
            if (bal < -16 || bal > 15) begin
              errors++;
              $display("FAIL %s_balance: running balance %0d expected within -16..15", e.name, bal);
            end
          end else begin
            bal = 0;
          end
        end
      end
    end
  end

  task automatic step(input logic r, input logic d_e, input logic [7:0] dat,
                      input logic [1:0] c, input logic isl, input logic [3:0] a,
                      input exp_t e);
    exp_t rst_e;
    @(posedge clk); #1;
    rst_e.exact = 1'b1; rst_e.vid = 1'b0; rst_e.w = 10'h354; rst_e.d = '0;
    rst_e.name = "reset";
    // A word still in flight when reset asserts is discarded and replaced by token 00
    if (!r && prev_rst_n && q.size() > 0) begin
      rst_e.name = "reset_discard";
      q[$] = rst_e;
    end
    rst_n = r; de = d_e; data = dat; ctl = c; island = isl; aux = a;
    drove = 1'b1;
    prev_rst_n = r;
    q.push_back(r ? e : rst_e);
  endtask

  function automatic exp_t ex(input logic v, input logic [9:0] w, input string n);
    exp_t e;
    e.exact = 1'b1; e.vid = v; e.w = w; e.d = '0; e.name = n;
    return e;
  endfunction

  task automatic vid(input logic [7:0] d, input logic [9:0] w, input string n);
    step(1'b1, 1'b1, d, 2'b00, 1'b0, 4'h0, ex(1'b1, w, n));
  endtask

  task automatic ctrl(input logic [1:0] c, input string n);
    step(1'b1, 1'b0, 8'h00, c, 1'b0, 4'h0, ex(1'b0, CTL_TOK[c], n));
  endtask

  initial begin
    exp_t e;
    int   nbytes;
    int   blen;
    // Reset held 4 clocks with video input present
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 8'hA5, 2'b00, 1'b0, 4'h0, ex(1'b0, 10'h354, "rst_hold"));
    vid(8'hA5, 10'h163, "after_rst_a5_0");
    vid(8'hA5, 10'h163, "after_rst_a5_1");
    // Zeros from cnt=0
    ctrl(2'b00, "ctl_pre_zeros");
    vid(8'h00, 10'h100, "zeros_0");
    vid(8'h00, 10'h3FF, "zeros_1");
    vid(8'h00, 10'h100, "zeros_2");
    // Ones from cnt=0, then control 11
    ctrl(2'b00, "ctl_pre_ones");
    vid(8'hFF, 10'h200, "ones_0");
    ctrl(2'b11, "ctl_after_ones");
    // Mode switch clears disparity
    vid(8'h00, 10'h100, "mswitch_0");
    ctrl(2'b01, "mswitch_ctl");
    vid(8'h00, 10'h100, "mswitch_1");
    // Control sweep
    for (int c = 0; c < 4; c++) ctrl(2'(c), "ctl_sweep");
    // TERC4 sweep
    for (int a = 0; a < 16; a++) begin
`ifdef XHDMIOUT_TERC4_EN
      step(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 4'(a), ex(1'b0, TERC_TOK[a], "terc4_sweep"));
`else
      step(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 4'(a), ex(1'b0, 10'h354, "terc4_off"));
`endif
    end
    // Priority: video over island, island over control
    step(1'b1, 1'b1, 8'hFF, 2'b11, 1'b1, 4'h5, ex(1'b1, 10'h200, "prio_de"));
`ifdef XHDMIOUT_TERC4_EN
    step(1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 4'h5, ex(1'b0, 10'h11E, "prio_island"));
`else
    step(1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 4'h5, ex(1'b0, 10'h0AB, "prio_island_off"));
`endif
    // Mid-stream reset: second zero word is in flight and is discarded
    ctrl(2'b00, "ctl_pre_midrst");
    vid(8'h00, 10'h100, "midrst_0");
    vid(8'h00, 10'h3FF, "midrst_1");
    step(1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 4'h0, ex(1'b0, 10'h354, "midrst"));
    vid(8'h00, 10'h100, "midrst_after_0");
    vid(8'h00, 10'h3FF, "midrst_after_1");
    // Random video bursts separated by control periods
    nbytes = 0;
    while (nbytes < 1500) begin
      blen = $urandom_range(40, 1);
      for (int i = 0; i < blen; i++) begin
        e.exact = 1'b0; e.vid = 1'b1; e.w = '0; e.d = 8'($urandom); e.name = "rand_vid";
        step(1'b1, 1'b1, e.d, 2'b00, 1'b0, 4'h0, e);
      end
      nbytes += blen;
      for (int i = 0; i < int'($urandom_range(3, 1)); i++) begin
        ctrl(2'($urandom), "rand_ctl");
      end
    end
    @(posedge clk); #1;
    drove = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
